camera_pack_fifo: RTL and testbench
===================================

CAMERA_PACK_FIFO -- requirements
Module: camera_pack_fifo

Interface
REQ-001 SHALL have parameter WR_WIDTH, default 8: bits per write word.
REQ-002 SHALL have parameter RATIO, default 4, legal 1/2/4/8: write words per read word; RD_WIDTH = WR_WIDTH*RATIO.
REQ-003 SHALL have parameter DEPTH_LOG2, default 10: storage = 2^DEPTH_LOG2 read words.
REQ-004 SHALL have parameter ALMOST_FULL_NUM, default 1000: almost_full threshold, in read words.
REQ-005 SHALL have parameter ALMOST_EMPTY_NUM, default 16: almost_empty threshold, in read words.
REQ-006 SHALL have parameter MSB_FIRST, default 0: 0 = first write lands in rd_data[WR_WIDTH-1:0]; 1 = first write lands in the top lane.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port flush, input, 1 bit: synchronous clear of all contents.
REQ-010 SHALL have port wr_en, input, 1 bit: write strobe.
REQ-011 SHALL have port wr_data, input, WR_WIDTH bits: write word.
REQ-012 SHALL have port wr_last, input, 1 bit: qualified by wr_en; commits a partial read word (frame/line end).
REQ-013 SHALL have port wr_full, output, 1 bit: storage full.
REQ-014 SHALL have port almost_full, output, 1 bit: level >= ALMOST_FULL_NUM.
REQ-015 SHALL have port rd_en, input, 1 bit: read strobe.
REQ-016 SHALL have port rd_data, output, RD_WIDTH bits: read word.
REQ-017 SHALL have port rd_valid, output, 1 bit: rd_data holds a newly read word this cycle.
REQ-018 SHALL have port rd_empty, output, 1 bit: no committed read words.
REQ-019 SHALL have port almost_empty, output, 1 bit: level <= ALMOST_EMPTY_NUM.
REQ-020 SHALL have port water_level, output, DEPTH_LOG2+1 bits: committed read-word count.
REQ-021 SHALL have port overflow, output, 1 bit: one-cycle pulse when a write is dropped.
REQ-022 SHALL have port underflow, output, 1 bit: one-cycle pulse when a read is dropped.

Function
REQ-023 SHALL pack accepted writes into a lane counter/shift register, lane order per MSB_FIRST.
REQ-024 SHALL commit the packed word to storage on the cycle the RATIO-th lane is written, or on an accepted write with wr_last=1; unwritten lanes SHALL be zero; the lane counter SHALL then return to 0.
REQ-025 SHALL accept a write iff wr_en=1 and wr_full=0; otherwise, with wr_en=1, drop the data and pulse overflow the next cycle.
REQ-026 SHALL assert wr_full iff water_level == 2^DEPTH_LOG2; a partial packer SHALL NOT count toward water_level.
REQ-027 SHALL accept a read iff rd_en=1 and rd_empty=0; rd_data and rd_valid SHALL update exactly 1 cycle after acceptance; rd_data SHALL hold its value when no read is accepted.
REQ-028 SHALL pulse underflow 1 cycle after rd_en=1 with rd_empty=1, with rd_valid=0 and pointers unchanged.
REQ-029 SHALL update water_level by +1 on commit only, -1 on read only, and leave it unchanged on simultaneous commit and read.
REQ-030 SHALL derive wr_full, rd_empty, almost_full and almost_empty from the registered water_level, i.e. valid the same cycle the level changes.
REQ-031 SHALL use DEPTH_LOG2-bit read/write pointers that wrap modulo 2^DEPTH_LOG2 with FIFO order preserved.
REQ-032 SHALL, on flush=1, zero the pointers, level and packer on the next edge, taking priority over a same-cycle write or read; rd_data SHALL hold and rd_valid SHALL be 0.

Reset
REQ-033 SHALL, while rst_n=0 (asynchronous), force pointers, level and packer to 0 and rd_data to 0; rd_valid, overflow, underflow, wr_full and almost_full to 0; rd_empty and almost_empty to 1.
REQ-034 SHALL resume normal operation on the first clk edge after rst_n deasserts; storage contents need no reset.

Verification
REQ-035 SHALL cover: defaults, write 0x11,0x22,0x33,0x44 then rd_en -> next cycle rd_data=0x44332211, rd_valid=1; with MSB_FIRST=1 -> 0x11223344.
REQ-036 SHALL cover: write 0xAA, then 0xBB with wr_last -> water_level=1; read -> 0x0000BBAA.
REQ-037 SHALL cover: 4096 writes -> almost_full at level 1000, wr_full at 1024; one further write -> overflow pulse, level stays 1024; drain 1024 words -> all in order.
REQ-038 SHALL cover: rd_en on an empty FIFO -> underflow pulse, rd_valid=0; simultaneous commit and read at level 5 -> level stays 5.
REQ-039 SHALL cover: 3000 words streamed through (pointer wrap) -> order intact.
REQ-040 SHALL cover: flush at level 7 with a half-filled packer -> level 0, rd_empty=1; rst_n pulsed low mid-write -> all outputs at reset values immediately, without a clk edge.

Source files
------------

// File: rtl/camera_pack_fifo.sv
// camera_pack_fifo: packs narrow camera write words into wide read words and
// buffers them in a single-clock FIFO with level, threshold and error flags.
module camera_pack_fifo #(
    parameter int WR_WIDTH         = 8,
    parameter int RATIO            = 4,
    parameter int DEPTH_LOG2       = 10,
    parameter int ALMOST_FULL_NUM  = 1000,
    parameter int ALMOST_EMPTY_NUM = 16,
    parameter int MSB_FIRST        = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          wr_en,
    input  logic [WR_WIDTH-1:0]           wr_data,
    input  logic                          wr_last,
    output logic                          wr_full,
    output logic                          almost_full,
    input  logic                          rd_en,
    output logic [WR_WIDTH*RATIO-1:0]     rd_data,
    output logic                          rd_valid,
    output logic                          rd_empty,
    output logic                          almost_empty,
    output logic [DEPTH_LOG2:0]           water_level,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int RD_WIDTH = WR_WIDTH * RATIO;
    localparam int DEPTH    = 1 << DEPTH_LOG2;
    localparam int LANE_W   = (RATIO > 1) ? $clog2(RATIO) : 1;

    localparam logic [LANE_W-1:0]     LAST_LANE  = LANE_W'(RATIO - 1);
    localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [31:0]           AF_NUM     = 32'(ALMOST_FULL_NUM);
    localparam logic [31:0]           AE_NUM     = 32'(ALMOST_EMPTY_NUM);

    // Storage array; contents are never reset, only the pointers are.
    logic [RD_WIDTH-1:0]   r_mem [DEPTH];

    logic [DEPTH_LOG2-1:0] r_wrPtr;
    logic [DEPTH_LOG2-1:0] r_rdPtr;
    logic [DEPTH_LOG2:0]   r_level;
    logic [LANE_W-1:0]     r_laneCnt;
    logic [RD_WIDTH-1:0]   r_packData;
    logic [RD_WIDTH-1:0]   r_rdData;
    logic                  r_rdValid;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wrAccept;
    logic                  w_rdAccept;
    logic                  w_lastLane;
    logic                  w_commit;
    logic [RD_WIDTH-1:0]   w_packNext;

    // Status flags come straight from the registered level so they track it
    // in the same cycle it changes.
    assign w_full       = (r_level == FULL_LEVEL);
    assign w_empty      = (r_level == '0);
    assign wr_full      = w_full;
    assign rd_empty     = w_empty;
    assign almost_full  = (32'(r_level) >= AF_NUM);
    assign almost_empty = (32'(r_level) <= AE_NUM);
    assign water_level  = r_level;
    assign rd_data      = r_rdData;
    assign rd_valid     = r_rdValid;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Flush wins over any same-cycle transfer, so accepts are masked by it.
    assign w_wrAccept = wr_en & ~w_full & ~flush;
    assign w_rdAccept = rd_en & ~w_empty & ~flush;
    assign w_lastLane = (r_laneCnt == LAST_LANE);
    assign w_commit   = w_wrAccept & (w_lastLane | wr_last);

    // Merge the incoming write word into the lane selected by the lane counter.
    always_comb begin
        w_packNext = r_packData;
        for (int k = 0; k < RATIO; k++) begin
            if (int'(r_laneCnt) == ((MSB_FIRST != 0) ? (RATIO - 1 - k) : k)) begin
                w_packNext[k*WR_WIDTH +: WR_WIDTH] = wr_data;
            end
        end
    end

    // Packer: accumulate lanes, restart from an all-zero word after each commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_laneCnt  <= '0;
            r_packData <= '0;
        end else if (flush) begin
            r_laneCnt  <= '0;
            r_packData <= '0;
        end else if (w_wrAccept) begin
            if (w_commit) begin
                r_laneCnt  <= '0;
                r_packData <= '0;
            end else begin
                r_laneCnt  <= r_laneCnt + 1'b1;
                r_packData <= w_packNext;
            end
        end
    end

    // Storage write port: a committed word lands at the write pointer.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[r_wrPtr] <= w_packNext;
        end
    end

    // Pointers and level; a commit and a read in the same cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else if (flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_commit) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_rdAccept) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_commit, w_rdAccept})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Read data register: loads only on an accepted read, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdData <= '0;
        end else if (w_rdAccept) begin
            r_rdData <= r_mem[r_rdPtr];
        end
    end

    // One-cycle strobes: read valid plus dropped-write and dropped-read pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdValid   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_rdValid   <= w_rdAccept;
            r_overflow  <= wr_en & w_full & ~flush;
            r_underflow <= rd_en & w_empty & ~flush;
        end
    end

endmodule

// File: tb/tb_camera_pack_fifo.sv
// tb_camera_pack_fifo: directed vectors, corner sequences and random streaming
// against a queue-based reference model, for LSB-first and MSB-first packing.
module tb_camera_pack_fifo;

    localparam int WR_WIDTH   = 8;
    localparam int RATIO      = 4;
    localparam int DEPTH_LOG2 = 10;
    localparam int DEPTH      = 1024;
    localparam int AF_NUM     = 1000;
    localparam int AE_NUM     = 16;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        flush   = 1'b0;
    logic        wr_en   = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_last = 1'b0;
    logic        rd_en   = 1'b0;

    logic        full0, af0, valid0, empty0, ae0, ovf0, unf0;
    logic [31:0] data0;
    logic [10:0] level0;
    logic        full1, af1, valid1, empty1, ae1, ovf1, unf1;
    logic [31:0] data1;
    logic [10:0] level1;

    camera_pack_fifo #(
        .WR_WIDTH(WR_WIDTH), .RATIO(RATIO), .DEPTH_LOG2(DEPTH_LOG2),
        .ALMOST_FULL_NUM(AF_NUM), .ALMOST_EMPTY_NUM(AE_NUM), .MSB_FIRST(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .wr_last(wr_last), .wr_full(full0), .almost_full(af0), .rd_en(rd_en),
        .rd_data(data0), .rd_valid(valid0), .rd_empty(empty0), .almost_empty(ae0),
        .water_level(level0), .overflow(ovf0), .underflow(unf0)
    );

    camera_pack_fifo #(
        .WR_WIDTH(WR_WIDTH), .RATIO(RATIO), .DEPTH_LOG2(DEPTH_LOG2),
        .ALMOST_FULL_NUM(AF_NUM), .ALMOST_EMPTY_NUM(AE_NUM), .MSB_FIRST(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .wr_last(wr_last), .wr_full(full1), .almost_full(af1), .rd_en(rd_en),
        .rd_data(data1), .rd_valid(valid1), .rd_empty(empty1), .almost_empty(ae1),
        .water_level(level1), .overflow(ovf1), .underflow(unf1)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference model: committed words per lane order, bytes of the open word.
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [7:0]  pend[$];
    logic [31:0] expData0 = 32'h0;
    logic [31:0] expData1 = 32'h0;
    bit          expValid = 1'b0;
    bit          expOver  = 1'b0;
    bit          expUnder = 1'b0;
    int          checks   = 0;
    int          errors   = 0;
    int          commits  = 0;

    typedef struct {
        bit          f;
        bit          we;
        logic [7:0]  wd;
        bit          wl;
        bit          re;
        logic [10:0] lvl;
        bit          vld;
        bit          unf;
        logic [31:0] d0;
        logic [31:0] d1;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        q0.delete();
        q1.delete();
        pend.delete();
        expData0 = 32'h0;
        expData1 = 32'h0;
        expValid = 1'b0;
        expOver  = 1'b0;
        expUnder = 1'b0;
    endtask

    task automatic modelStep(input bit f, input bit we, input logic [7:0] wd, input bit wl, input bit re);
        bit          isFull;
        bit          isEmpty;
        logic [31:0] w0;
        logic [31:0] w1;
        if (f) begin
            q0.delete();
            q1.delete();
            pend.delete();
            expValid = 1'b0;
            expOver  = 1'b0;
            expUnder = 1'b0;
        end else begin
            isFull   = (q0.size() == DEPTH);
            isEmpty  = (q0.size() == 0);
            expOver  = we && isFull;
            expUnder = re && isEmpty;
            expValid = re && !isEmpty;
            if (re && !isEmpty) begin
                expData0 = q0.pop_front();
                expData1 = q1.pop_front();
            end
            if (we && !isFull) begin
                pend.push_back(wd);
                if (pend.size() == RATIO || wl) begin
                    w0 = 32'h0;
                    w1 = 32'h0;
                    for (int i = 0; i < pend.size(); i++) begin
                        w0 = w0 | (32'(pend[i]) << (WR_WIDTH * i));
                        w1 = w1 | (32'(pend[i]) << (WR_WIDTH * (RATIO - 1 - i)));
                    end
                    q0.push_back(w0);
                    q1.push_back(w1);
                    pend.delete();
                    commits++;
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit f, input bit we, input logic [7:0] wd, input bit wl, input bit re);
        @(negedge clk);
        flush   = f;
        wr_en   = we;
        wr_data = wd;
        wr_last = wl;
        rd_en   = re;
        modelStep(f, we, wd, wl, re);
        @(posedge clk);
        #1;
    endtask

    task automatic checkModel();
        int lvl;
        lvl = q0.size();
        checkOutput("water_level0", 64'(level0), 64'(lvl));
        checkOutput("wr_full0", 64'(full0), 64'(lvl == DEPTH));
        checkOutput("almost_full0", 64'(af0), 64'(lvl >= AF_NUM));
        checkOutput("rd_empty0", 64'(empty0), 64'(lvl == 0));
        checkOutput("almost_empty0", 64'(ae0), 64'(lvl <= AE_NUM));
        checkOutput("rd_valid0", 64'(valid0), 64'(expValid));
        checkOutput("overflow0", 64'(ovf0), 64'(expOver));
        checkOutput("underflow0", 64'(unf0), 64'(expUnder));
        checkOutput("rd_data0", 64'(data0), 64'(expData0));
        checkOutput("water_level1", 64'(level1), 64'(lvl));
        checkOutput("wr_full1", 64'(full1), 64'(lvl == DEPTH));
        checkOutput("almost_full1", 64'(af1), 64'(lvl >= AF_NUM));
        checkOutput("rd_empty1", 64'(empty1), 64'(lvl == 0));
        checkOutput("almost_empty1", 64'(ae1), 64'(lvl <= AE_NUM));
        checkOutput("rd_valid1", 64'(valid1), 64'(expValid));
        checkOutput("overflow1", 64'(ovf1), 64'(expOver));
        checkOutput("underflow1", 64'(unf1), 64'(expUnder));
        checkOutput("rd_data1", 64'(data1), 64'(expData1));
    endtask

    task automatic stepCheck(input bit f, input bit we, input logic [7:0] wd, input bit wl, input bit re);
        applyStimulus(f, we, wd, wl, re);
        checkModel();
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        bit         rwe;
        bit         rre;
        bit         rwl;
        logic [7:0] rwd;

        //                f  we  wd     wl re  lvl   vld unf  d0            d1
        vecs[0] = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 32'h00000000, 32'h00000000};
        vecs[1] = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 32'h00000000, 32'h00000000};
        vecs[2] = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 32'h00000000, 32'h00000000};
        vecs[3] = '{1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 11'd1, 1'b0, 1'b0, 32'h00000000, 32'h00000000};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 11'd0, 1'b1, 1'b0, 32'h44332211, 32'h11223344};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 32'h44332211, 32'h11223344};
        vecs[6] = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 32'h44332211, 32'h11223344};
        vecs[7] = '{1'b0, 1'b1, 8'hBB, 1'b1, 1'b0, 11'd1, 1'b0, 1'b0, 32'h44332211, 32'h11223344};
        vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 11'd0, 1'b1, 1'b0, 32'h0000BBAA, 32'hAABB0000};
        vecs[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 11'd0, 1'b0, 1'b1, 32'h0000BBAA, 32'hAABB0000};

        // Reset state.
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkModel();
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: packing order, partial commit, empty read.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].f, vecs[i].we, vecs[i].wd, vecs[i].wl, vecs[i].re);
            checkOutput($sformatf("vec%0d.level", i), 64'(level0), 64'(vecs[i].lvl));
            checkOutput($sformatf("vec%0d.rd_valid", i), 64'(valid0), 64'(vecs[i].vld));
            checkOutput($sformatf("vec%0d.underflow", i), 64'(unf0), 64'(vecs[i].unf));
            checkOutput($sformatf("vec%0d.rd_data_lsb", i), 64'(data0), 64'(vecs[i].d0));
            checkOutput($sformatf("vec%0d.rd_data_msb", i), 64'(data1), 64'(vecs[i].d1));
            checkModel();
        end

        // Fill to full, overflow, then drain in order.
        for (int i = 0; i < 4096; i++) begin
            stepCheck(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
            if (i == 3995) checkOutput("almost_full_at_999", 64'(af0), 64'(0));
            if (i == 3999) checkOutput("almost_full_at_1000", 64'(af0), 64'(1));
        end
        checkOutput("full_level", 64'(level0), 64'(1024));
        checkOutput("full_flag", 64'(full0), 64'(1));
        stepCheck(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
        checkOutput("overflow_pulse", 64'(ovf0), 64'(1));
        checkOutput("level_after_overflow", 64'(level0), 64'(1024));
        stepCheck(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("overflow_one_cycle", 64'(ovf0), 64'(0));
        for (int i = 0; i < 1024; i++) begin
            stepCheck(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        end
        checkOutput("drained_empty", 64'(empty0), 64'(1));

        // Simultaneous commit and read at level 5.
        for (int i = 0; i < 23; i++) begin
            stepCheck(1'b0, 1'b1, 8'(i + 1), 1'b0, 1'b0);
        end
        checkOutput("level5_before", 64'(level0), 64'(5));
        stepCheck(1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
        checkOutput("level5_commit_read", 64'(level0), 64'(5));
        checkOutput("valid_commit_read", 64'(valid0), 64'(1));

        // Flush at level 7 with a half-filled packer, with a write and read pending.
        for (int i = 0; i < 10; i++) begin
            stepCheck(1'b0, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        end
        checkOutput("level7", 64'(level0), 64'(7));
        stepCheck(1'b1, 1'b1, 8'hEE, 1'b0, 1'b1);
        checkOutput("flush_level", 64'(level0), 64'(0));
        checkOutput("flush_empty", 64'(empty0), 64'(1));
        checkOutput("flush_valid", 64'(valid0), 64'(0));
        for (int i = 0; i < 4; i++) begin
            stepCheck(1'b0, 1'b1, 8'(8'hC1 + i), 1'b0, 1'b0);
        end
        stepCheck(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("after_flush_word", 64'(data0), 64'(32'hC4C3C2C1));

        // Asynchronous reset mid-write, observed before any clock edge.
        for (int i = 0; i < 9; i++) begin
            stepCheck(1'b0, 1'b1, 8'(8'h71 + i), 1'b0, 1'b0);
        end
        stepCheck(1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
        checkOutput("pre_reset_valid", 64'(valid0), 64'(1));
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rd_data0", 64'(data0), 64'(0));
        checkOutput("async_rd_data1", 64'(data1), 64'(0));
        checkOutput("async_rd_valid", 64'(valid0), 64'(0));
        checkOutput("async_level", 64'(level0), 64'(0));
        checkOutput("async_rd_empty", 64'(empty0), 64'(1));
        checkOutput("async_almost_empty", 64'(ae0), 64'(1));
        checkOutput("async_wr_full", 64'(full0), 64'(0));
        checkOutput("async_almost_full", 64'(af0), 64'(0));
        checkOutput("async_overflow", 64'(ovf0), 64'(0));
        checkOutput("async_underflow", 64'(unf0), 64'(0));
        modelReset();
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_last = 1'b0;
        @(posedge clk);
        #1;
        checkModel();
        @(negedge clk);
        rst_n = 1'b1;

        // Random streaming through pointer wrap-around.
        commits = 0;
        for (int c = 0; c < 40000 && commits < 3000; c++) begin
            rwe = ($urandom_range(0, 9) < 9);
            rre = ($urandom_range(0, 99) < ((((c / 2000) % 2) == 1) ? 60 : 15));
            rwl = ($urandom_range(0, 19) == 0);
            rwd = 8'($urandom);
            stepCheck(1'b0, rwe, rwd, rwl, rre);
        end
        checkOutput("stream_3000_words", 64'(commits >= 3000), 64'(1));
        for (int c = 0; c < 5000 && q0.size() > 0; c++) begin
            stepCheck(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        end
        checkOutput("stream_drained", 64'(empty0), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
